mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares one single-port synchronous RAM between the pipelined core's instruction-fetch port and its data port. Accepts one access per cycle, with priority and starvation control, and returns read data one cycle later to the correct requester. The core stalls fetch or the MEM stage whenever its ready is low. The arbiter sits between the core's `iaddr`/`daddr`/`d_r`/`d_w` signals and the unified RAM macro.

## Interface
- `AW`, default 10: word-address width for both ports and the RAM.
- `DW`, default 32: data width.
- `MAX_D_STREAK`, default 4: maximum consecutive data grants allowed while a fetch is pending.
- `CLK  in  1`: single clock, rising edge.
- `RSTn  in  1`: asynchronous, active-low reset.
- `i_req  in  1`: fetch request. Held with `i_addr` stable until `i_ready`.
- `i_addr  in  AW`: fetch word address.
- `i_ready  out  1`: fetch accepted this cycle. Combinational grant.
- `i_valid  out  1`: `i_rdata` valid. One-cycle pulse, one cycle after grant.
- `i_rdata  out  DW`: fetched word.
- `d_req  in  1`: data request. Held with `d_we`, `d_addr` and `d_wdata` stable until `d_ready`.
- `d_we  in  1`: 1 selects write, 0 selects read.
- `d_addr  in  AW`: data word address.
- `d_wdata  in  DW`: store data.
- `d_ready  out  1`: data request accepted this cycle.
- `d_valid  out  1`: read data valid or write acknowledged. Pulse, one cycle after grant.
- `d_rdata  out  DW`: load data.
- `m_en  out  1`: RAM enable.
- `m_we  out  1`: RAM write enable.
- `m_addr  out  AW`: RAM address.
- `m_wdata  out  DW`: RAM write data.
- `m_rdata  in  DW`: RAM read data. Valid the cycle after `m_en`.

## Operation
- At most one grant per cycle.
- Priority: data beats fetch, because the MEM stage is older than IF.
- Exception: if `i_req` is high and `streak == MAX_D_STREAK`, fetch wins.
- `streak` counter, width `$clog2(MAX_D_STREAK+1)`:
  - increments on a data grant while `i_req` is high;
  - clears on a fetch grant or whenever `i_req` is low;
  - saturates at `MAX_D_STREAK`.
- Grant drives the RAM combinationally:
  - `m_en = i_ready | d_ready`;
  - `m_addr`, `m_we` and `m_wdata` come from the winner;
  - `m_we = d_ready & d_we`.
- When idle: `m_we = 0`, `m_addr = 0`, `m_wdata = 0`.
- Response FSM `resp_q` has three states: `RESP_NONE`, `RESP_I`, `RESP_D`.
  - Next state is `RESP_I` on a fetch grant, `RESP_D` on a data grant, otherwise `RESP_NONE`.
  - Every state may go to any state each cycle, so back-to-back accesses are fully pipelined.
- Response outputs:
  - `i_valid = (resp_q == RESP_I)`;
  - `d_valid = (resp_q == RESP_D)`;
  - `i_rdata` and `d_rdata` are both driven from `m_rdata` and are meaningful only while their valid is high.
- A write grant also produces a `d_valid` pulse (write ack); `d_rdata` is don't-care during that pulse.
- A request withdrawn before ready is a protocol violation; the bench asserts against it.

## Timing
- Grant latency is 0 cycles: ready is combinational from req and state.
- Response latency is exactly 1 cycle after the grant edge.
- Throughput: 1 access per cycle.
- Simultaneous `i_req` and `d_req` resolve as described under Operation. The loser's ready stays low and it retries next cycle.
- Reset values: `resp_q = RESP_NONE`, `streak = 0`, all valid/ready/`m_*` outputs 0.
- Reset asserted mid-access drops the in-flight response: no valid pulse after RSTn deasserts.
- The first grant is possible in the first cycle after reset release.

## Configuration
- `MEM_ARB_PERF_EN` defined adds three outputs:
  - `perf_conflict  out 32`: cycles with both requests high;
  - `perf_i_stall  out 32`: cycles with `i_req & !i_ready`;
  - `perf_d_stall  out 32`: cycles with `d_req & !d_ready`.
- The perf counters reset to 0 and wrap modulo 2^32.
- Without the macro these ports and the counters do not exist; arbitration behaviour is identical in both builds.

## Structure
- `mem_arb_pkg` holds the `resp_e` enum (`RESP_NONE`, `RESP_I`, `RESP_D`) and default `AW`/`DW` localparams.
- Sub-module `mem_arb_perf`, instantiated only under `MEM_ARB_PERF_EN`, holds the three counters.

## Test plan
- Only `i_req` at addresses 0..7 for 8 cycles -> `i_ready` is 1 every cycle; `i_valid` runs 1..8 cycles later with `i_rdata` equal to preloaded `mem[n]`.
- Hold `d_req` write to addr 5 with `0xDEADBEEF`, then read addr 5 -> `d_valid` after each access; read returns `0xDEADBEEF`; `m_we` high only in the write grant cycle.
- `i_req` and `d_req` both high continuously, `MAX_D_STREAK=4` -> grant pattern is D,D,D,D,I repeating; `i_valid` appears every 5th cycle.
- Assert `i_req` and `d_req` in the same cycle after an idle period -> data is granted first, fetch next cycle, and responses return in that order.
- Pull RSTn low in the cycle after a read grant -> no `d_valid`; all outputs are 0 during reset; the first access after release is granted normally.
- With `MEM_ARB_PERF_EN`, 10 cycles of dual request -> `perf_conflict` = 10, `perf_i_stall` = 8, `perf_d_stall` = 2.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the instruction/data RAM port arbiter.
package mem_arb_pkg;

    localparam int MEM_ARB_AW = 10;
    localparam int MEM_ARB_DW = 32;

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_I    = 2'd1,
        RESP_D    = 2'd2
    } resp_e;

endpackage

// File: rtl/mem_arb_perf.sv
// Conflict and stall event counters for the RAM port arbiter.
// Only instantiated when MEM_ARB_PERF_EN is defined.
module mem_arb_perf (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        i_req,
    input  logic        i_ready,
    input  logic        d_req,
    input  logic        d_ready,
    output logic [31:0] perf_conflict,
    output logic [31:0] perf_i_stall,
    output logic [31:0] perf_d_stall
);

    logic conflict_evt;
    logic i_stall_evt;
    logic d_stall_evt;

    assign conflict_evt = i_req & d_req;
    assign i_stall_evt  = i_req & ~i_ready;
    assign d_stall_evt  = d_req & ~d_ready;

    // Counters wrap naturally modulo 2^32.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            perf_conflict <= '0;
            perf_i_stall  <= '0;
            perf_d_stall  <= '0;
        end else begin
            if (conflict_evt) perf_conflict <= perf_conflict + 32'd1;
            if (i_stall_evt)  perf_i_stall  <= perf_i_stall + 32'd1;
            if (d_stall_evt)  perf_d_stall  <= perf_d_stall + 32'd1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the core's fetch and data ports onto one single-port synchronous RAM.
// Optional perf counters: define MEM_ARB_PERF_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW           = MEM_ARB_AW,
    parameter int DW           = MEM_ARB_DW,
    parameter int MAX_D_STREAK = 4
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_ready,
    output logic          i_valid,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ready,
    output logic          d_valid,
    output logic [DW-1:0] d_rdata,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]   perf_conflict,
    output logic [31:0]   perf_i_stall,
    output logic [31:0]   perf_d_stall
`endif
);

    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    resp_e         resp_q;
    resp_e         resp_next;
    logic [SW-1:0] streak_reg;
    logic [SW-1:0] streak_next;
    logic          fetch_due;

    // Fetch overrides data once the data side has used up its streak budget.
    assign fetch_due = i_req & (streak_reg == STREAK_MAX);
    // Grants are held low while in reset so nothing reaches the RAM.
    assign d_ready   = RSTn & d_req & ~fetch_due;
    assign i_ready   = RSTn & i_req & ~d_ready;

    always_comb begin
        streak_next = streak_reg;
        if (!i_req || i_ready) begin
            streak_next = '0;
        end else if (d_ready && (streak_reg != STREAK_MAX)) begin
            streak_next = streak_reg + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            streak_reg <= '0;
        end else begin
            streak_reg <= streak_next;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            resp_q <= RESP_NONE;
        end else begin
            resp_q <= resp_next;
        end
    end

    always_comb begin
        resp_next = RESP_NONE;
        if (i_ready) begin
            resp_next = RESP_I;
        end else if (d_ready) begin
            resp_next = RESP_D;
        end
    end

    always_comb begin
        i_valid = (resp_q == RESP_I);
        d_valid = (resp_q == RESP_D);
        m_en    = i_ready | d_ready;
        m_we    = d_ready & d_we;
        m_addr  = '0;
        m_wdata = '0;
        if (d_ready) begin
            m_addr  = d_addr;
            m_wdata = d_wdata;
        end else if (i_ready) begin
            m_addr  = i_addr;
        end
    end

    assign i_rdata = m_rdata;
    assign d_rdata = m_rdata;

`ifdef MEM_ARB_PERF_EN
    mem_arb_perf u_perf (
        .CLK           (CLK),
        .RSTn          (RSTn),
        .i_req         (i_req),
        .i_ready       (i_ready),
        .d_req         (d_req),
        .d_ready       (d_ready),
        .perf_conflict (perf_conflict),
        .perf_i_stall  (perf_i_stall),
        .perf_d_stall  (perf_d_stall)
    );
`endif

endmodule
